// File: rtl/fifo_write_arbiter_if.sv
// Bundle of the producer request bus and the shared Fifo write port seen by fifo_write_arbiter.
// The master modport is the producer/Fifo side; the slave modport is the arbiter itself.
interface fifo_write_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SIZE  = 8
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ*SIZE-1:0] data_in;
  logic [N_REQ-1:0]      grant;
  logic                  fifo_full;
  logic                  fifo_write_enable;
  logic [SIZE-1:0]       fifo_data_in;
  logic                  busy;

  modport master (
    output req, data_in, fifo_full,
    input  grant, fifo_write_enable, fifo_data_in, busy
  );

  modport slave (
    input  req, data_in, fifo_full,
    output grant, fifo_write_enable, fifo_data_in, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one Fifo write port among N_REQ producers, bounded bursts.
// Define FIFO_ARB_COUNT_EN to add a saturating 16-bit accepted_count output.
module fifo_write_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SIZE  = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_write_arbiter_if.slave   bus
`ifdef FIFO_ARB_COUNT_EN
  ,
  output logic [15:0]           accepted_count
`endif
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic {StIdle, StOwn} state_e;

  state_e           r_state, w_state_d;
  logic [OW-1:0]    r_owner, w_owner_d;
  logic [OW-1:0]    r_last_owner, w_last_owner_d;
  logic [CW-1:0]    r_count, w_count_d;
  logic [N_REQ-1:0] r_grant, w_grant_d;

  logic [OW-1:0]    w_base;
  logic [OW-1:0]    w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic [N_REQ-1:0] w_owner_oh;
  logic             w_accept;
  logic             w_burst_end;
  logic             w_others;

  // First requester after base, wrapping; base itself is checked last.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    base);
    logic [OW-1:0] idx;
    logic [OW-1:0] pick;
    pick = base;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OW'((int'(base) + k) % N_REQ);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign w_base      = (r_state == StOwn) ? r_owner : r_last_owner;
  assign w_pick      = rr_pick(bus.req, w_base);
  assign w_pick_oh   = N_REQ'(1) << w_pick;
  assign w_owner_oh  = N_REQ'(1) << r_owner;
  assign w_accept    = (r_state == StOwn) & bus.req[r_owner] & ~bus.fifo_full;
  assign w_burst_end = w_accept & (r_count == CW'(BURST - 1));
  assign w_others    = |(bus.req & ~w_owner_oh);

  assign bus.grant             = r_grant;
  assign bus.busy              = (r_state == StOwn);
  assign bus.fifo_write_enable = w_accept;
  assign bus.fifo_data_in      = bus.data_in[r_owner * SIZE +: SIZE];

  always_comb begin
    w_state_d      = r_state;
    w_owner_d      = r_owner;
    w_last_owner_d = r_last_owner;
    w_count_d      = r_count;
    w_grant_d      = r_grant;
    unique case (r_state)
      StIdle: begin
        if (|bus.req) begin
          w_state_d = StOwn;
          w_owner_d = w_pick;
          w_grant_d = w_pick_oh;
          w_count_d = '0;
        end
      end
      StOwn: begin
        if (!bus.req[r_owner] || w_burst_end) begin
          w_last_owner_d = r_owner;
          w_count_d      = '0;
          if (w_others) begin
            w_owner_d = w_pick;
            w_grant_d = w_pick_oh;
          end else if (!bus.req[r_owner]) begin
            w_state_d = StIdle;
            w_grant_d = '0;
          end
          // Otherwise the sole requester is re-granted for a fresh burst.
        end else if (w_accept) begin
          w_count_d = r_count + CW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_owner      <= '0;
      r_last_owner <= OW'(N_REQ - 1);
      r_count      <= '0;
      r_grant      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_last_owner <= w_last_owner_d;
      r_count      <= w_count_d;
      r_grant      <= w_grant_d;
    end
  end

`ifdef FIFO_ARB_COUNT_EN
  logic [15:0] r_accepted_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_accepted_count <= '0;
    end else if (w_accept && (r_accepted_count != 16'hFFFF)) begin
      r_accepted_count <= r_accepted_count + 16'd1;
    end
  end

  assign accepted_count = r_accepted_count;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (N_REQ=4, SIZE=8, BURST=4).
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fifo_write_arbiter_if #(.N_REQ(4), .SIZE(8)) bus ();

`ifdef FIFO_ARB_COUNT_EN
  logic [15:0] accepted_count;
`endif

  fifo_write_arbiter #(
    .N_REQ(4),
    .SIZE (8),
    .BURST(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave)
`ifdef FIFO_ARB_COUNT_EN
    ,
    .accepted_count(accepted_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = 4'b0000;
    bus.fifo_full = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req       = 4'b1111;
    bus.fifo_full = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (bus.grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant actual=%b required=0000", bus.grant);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy actual=%b required=0", bus.busy);
    end
    checks++;
    if (bus.fifo_write_enable !== 1'b0) begin
      errors++; $display("FAIL reset_we actual=%b required=0", bus.fifo_write_enable);
    end
    reset   = 1'b0;
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    #1;
    checks++;
    if (bus.grant !== 4'b0000 || bus.fifo_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_idle actual=%b/%b required=0000/0", bus.grant, bus.fifo_write_enable);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (bus.grant !== 4'b0001 || bus.fifo_write_enable !== 1'b1 ||
          bus.fifo_data_in !== 8'hA0) begin
        errors++;
        $display("FAIL single_write%0d actual=%b/%b/%h required=0001/1/a0", c, bus.grant,
                 bus.fifo_write_enable, bus.fifo_data_in);
      end
      tick();
    end
    bus.req = 4'b0000;
    #1;
    checks++;
    if (bus.fifo_write_enable !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drop actual=%b/%b required=0/1", bus.fifo_write_enable, bus.busy);
    end
    tick();
    #1;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_idle_after actual=%b/%b required=0000/0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int c = 0; c < 17; c++) begin
      exp_g = 4'(1 << ((c / 4) % 4));
      exp_d = 8'(8'hA0 + ((c / 4) % 4));
      #1;
      checks++;
      if (bus.grant !== exp_g || bus.fifo_write_enable !== 1'b1 || bus.fifo_data_in !== exp_d) begin
        errors++;
        $display("FAIL rr_cycle%0d actual=%b/%b/%h required=%b/1/%h", c, bus.grant,
                 bus.fifo_write_enable, bus.fifo_data_in, exp_g, exp_d);
      end
      tick();
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.req = 4'b0101;
    tick();
    for (int c = 0; c < 7; c++) begin
      bus.fifo_full = (c >= 2 && c < 5);
      #1;
      checks++;
      if (bus.grant !== 4'b0001 || bus.fifo_write_enable !== !bus.fifo_full) begin
        errors++;
        $display("FAIL stall_cycle%0d actual=%b/%b required=0001/%b", c, bus.grant,
                 bus.fifo_write_enable, !bus.fifo_full);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.grant !== 4'b0100 || bus.fifo_write_enable !== 1'b1 || bus.fifo_data_in !== 8'hA2) begin
      errors++;
      $display("FAIL stall_handoff actual=%b/%b/%h required=0100/1/a2", bus.grant,
               bus.fifo_write_enable, bus.fifo_data_in);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_drop_handoff();
    do_reset();
    bus.req = 4'b1010;
    tick();
    #1;
    checks++;
    if (bus.grant !== 4'b0010 || bus.fifo_write_enable !== 1'b1 || bus.fifo_data_in !== 8'hA1) begin
      errors++;
      $display("FAIL drop_first actual=%b/%b/%h required=0010/1/a1", bus.grant,
               bus.fifo_write_enable, bus.fifo_data_in);
    end
    tick();
    bus.req = 4'b1000;
    #1;
    checks++;
    if (bus.grant !== 4'b0010 || bus.fifo_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL drop_cycle actual=%b/%b required=0010/0", bus.grant, bus.fifo_write_enable);
    end
    tick();
    #1;
    checks++;
    if (bus.grant !== 4'b1000 || bus.fifo_write_enable !== 1'b1 || bus.fifo_data_in !== 8'hA3) begin
      errors++;
      $display("FAIL drop_handoff actual=%b/%b/%h required=1000/1/a3", bus.grant,
               bus.fifo_write_enable, bus.fifo_data_in);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b1111;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.fifo_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL midreset actual=%b/%b/%b required=0000/0/0", bus.grant, bus.busy,
               bus.fifo_write_enable);
    end
    reset   = 1'b0;
    bus.req = 4'b1001;
    tick();
    #1;
    checks++;
    if (bus.grant !== 4'b0001 || bus.fifo_data_in !== 8'hA0) begin
      errors++;
      $display("FAIL midreset_regrant actual=%b/%h required=0001/a0", bus.grant, bus.fifo_data_in);
    end
    bus.req = 4'b0000;
    tick();
  endtask

`ifdef FIFO_ARB_COUNT_EN
  task automatic test_accept_count();
    int occ = 0;
    int max_occ = 0;
    int writes = 0;
    int cyc = 0;
    int we;
    int drain;
    do_reset();
    checks++;
    if (accepted_count !== 16'd0) begin
      errors++; $display("FAIL count_reset actual=%0d required=0", accepted_count);
    end
    bus.req = 4'b0001;
    while (writes < 40 && cyc < 500) begin
      bus.fifo_full = (occ >= 5);
      #1;
      we     = bus.fifo_write_enable ? 1 : 0;
      writes += we;
      drain  = (cyc >= 5 && occ > 0) ? 1 : 0;
      occ    = occ + we - drain;
      if (occ > max_occ) max_occ = occ;
      cyc++;
      tick();
    end
    bus.req       = 4'b0000;
    bus.fifo_full = 1'b0;
    #1;
    checks++;
    if (writes != 40) begin
      errors++; $display("FAIL count_timeout actual=%0d required=40", writes);
    end
    checks++;
    if (accepted_count !== 16'd40) begin
      errors++; $display("FAIL count_value actual=%0d required=40", accepted_count);
    end
    checks++;
    if (max_occ > 5) begin
      errors++; $display("FAIL count_overflow actual=%0d required<=5", max_occ);
    end
    tick();
  endtask
`endif

  initial begin
    reset         = 1'b1;
    bus.req       = 4'b0000;
    bus.fifo_full = 1'b0;
    bus.data_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_handoff();
    test_reset_mid();
`ifdef FIFO_ARB_COUNT_EN
    test_accept_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
